// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED pattern generator.
// One shared prescaler produces a tick every 2^CBITS clocks and one shared
// DBITS-bit PWM counter runs every clock, so all channels stay phase-aligned.
// Each channel holds its own mode (off/on/blink/pwm/burst/breathe) and is
// reconfigured through a single-cycle write strobe.
// Optional feature macro: LED_PATTERN_BREATHE_EN enables mode 5 (BREATHE);
// without it no breathe registers exist and mode 5 decodes as OFF.
//
// Per-channel mode state:
//   state      | meaning
//   M_OFF      | led held low
//   M_ON       | led held high
//   M_BLINK    | led = phase, phase toggles on every tick
//   M_PWM      | led = pwm_cnt < duty (duty held in cnt_q)
//   M_BURST    | led = phase, counted pulses, cnt_q = pulses remaining
//   M_BREATHE  | led = pwm_cnt < bduty, bduty ramps up/down one step per tick
//   M_RSV6/7   | reserved, behaves as OFF

module led_pattern_gen #(
    parameter  int NCHAN = 3,
    parameter  int CBITS = 21,
    parameter  int DBITS = 8,
    localparam int CW    = $clog2(NCHAN)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr,
    input  logic [CW-1:0]    i_chan,
    input  logic [2:0]       i_mode,
    input  logic [DBITS-1:0] i_arg,
    output logic [NCHAN-1:0] o_led,
    output logic [NCHAN-1:0] o_done
);

    typedef enum logic [2:0] {
        M_OFF     = 3'd0,
        M_ON      = 3'd1,
        M_BLINK   = 3'd2,
        M_PWM     = 3'd3,
        M_BURST   = 3'd4,
        M_BREATHE = 3'd5,
        M_RSV6    = 3'd6,
        M_RSV7    = 3'd7
    } mode_e;

    localparam logic [CBITS-1:0] PRE_MAX = '1;
    localparam logic [DBITS-1:0] D_MAX   = '1;
    localparam logic [DBITS-1:0] D_ONE   = DBITS'(1);

    // Shared timebase
    logic [CBITS-1:0] pre_q, pre_d;
    logic [DBITS-1:0] pwm_q, pwm_d;
    logic             tick;

    // Per-channel state
    mode_e            mode_q [NCHAN];
    mode_e            mode_d [NCHAN];
    logic [DBITS-1:0] cnt_q  [NCHAN];
    logic [DBITS-1:0] cnt_d  [NCHAN];
    logic [NCHAN-1:0] phase_q, phase_d;
    logic [NCHAN-1:0] led_q, led_d;
    logic [NCHAN-1:0] done_q, done_d;
    logic [NCHAN-1:0] wr_hit;

`ifdef LED_PATTERN_BREATHE_EN
    logic [DBITS-1:0] bduty_q [NCHAN];
    logic [DBITS-1:0] bduty_d [NCHAN];
    // 0 = ramping up, 1 = ramping down
    logic [NCHAN-1:0] bdir_q, bdir_d;
`endif

    assign tick = (pre_q == PRE_MAX);

    // Free-running prescaler and PWM counter; both simply wrap.
    always_comb begin
        pre_d = pre_q + 1'b1;
        pwm_d = pwm_q + 1'b1;
    end

    // Decode the write strobe into a per-channel hit; an out-of-range
    // channel number matches nothing and the write is dropped.
    always_comb begin
        wr_hit = '0;
        for (int n = 0; n < NCHAN; n++) begin
            wr_hit[n] = i_wr && (i_chan == CW'(n));
        end
    end

    // Per-channel next-state and registered LED/done values.
    always_comb begin
        for (int n = 0; n < NCHAN; n++) begin
            mode_d[n]  = mode_q[n];
            cnt_d[n]   = cnt_q[n];
            phase_d[n] = phase_q[n];
            done_d[n]  = 1'b0;
            led_d[n]   = 1'b0;
`ifdef LED_PATTERN_BREATHE_EN
            bduty_d[n] = bduty_q[n];
            bdir_d[n]  = bdir_q[n];
`endif

            // LED follows the state held before this edge, giving the
            // single cycle of latency from a write to the pin.
            case (mode_q[n])
                M_ON:             led_d[n] = 1'b1;
                M_BLINK, M_BURST: led_d[n] = phase_q[n];
                M_PWM:            led_d[n] = (pwm_q < cnt_q[n]);
`ifdef LED_PATTERN_BREATHE_EN
                M_BREATHE:        led_d[n] = (pwm_q < bduty_q[n]);
`endif
                default:          led_d[n] = 1'b0;
            endcase

            if (wr_hit[n]) begin
                // A write always wins over a tick in the same cycle and
                // silently cancels any burst in progress.
                mode_d[n]  = mode_e'(i_mode);
                cnt_d[n]   = i_arg;
                phase_d[n] = 1'b0;
                case (mode_e'(i_mode))
                    M_BLINK: phase_d[n] = 1'b1;
                    M_BURST: begin
                        if (i_arg == '0) begin
                            // Empty burst completes immediately.
                            mode_d[n] = M_OFF;
                            done_d[n] = 1'b1;
                        end else begin
                            phase_d[n] = 1'b1;
                        end
                    end
`ifdef LED_PATTERN_BREATHE_EN
                    M_BREATHE: begin
                        bduty_d[n] = '0;
                        bdir_d[n]  = 1'b0;
                    end
`endif
                    default: ;
                endcase
            end else if (tick) begin
                case (mode_q[n])
                    M_BLINK: phase_d[n] = ~phase_q[n];
                    M_BURST: begin
                        if (phase_q[n]) begin
                            phase_d[n] = 1'b0;
                            cnt_d[n]   = cnt_q[n] - 1'b1;
                        end else if (cnt_q[n] != '0) begin
                            phase_d[n] = 1'b1;
                        end else begin
                            mode_d[n] = M_OFF;
                            done_d[n] = 1'b1;
                        end
                    end
`ifdef LED_PATTERN_BREATHE_EN
                    M_BREATHE: begin
                        if (!bdir_q[n]) begin
                            bduty_d[n] = bduty_q[n] + 1'b1;
                            if (bduty_q[n] == D_MAX - D_ONE) bdir_d[n] = 1'b1;
                        end else begin
                            bduty_d[n] = bduty_q[n] - 1'b1;
                            if (bduty_q[n] == D_ONE) bdir_d[n] = 1'b0;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    // State registers with synchronous active-low reset; reset beats a
    // simultaneous write and drops any pending done pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pre_q   <= '0;
            pwm_q   <= '0;
            phase_q <= '0;
            led_q   <= '0;
            done_q  <= '0;
            for (int n = 0; n < NCHAN; n++) begin
                mode_q[n] <= M_OFF;
                cnt_q[n]  <= '0;
            end
        end else begin
            pre_q   <= pre_d;
            pwm_q   <= pwm_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            done_q  <= done_d;
            for (int n = 0; n < NCHAN; n++) begin
                mode_q[n] <= mode_d[n];
                cnt_q[n]  <= cnt_d[n];
            end
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    // Breathe ramp registers, present only when the feature is built.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            bdir_q <= '0;
            for (int n = 0; n < NCHAN; n++) begin
                bduty_q[n] <= '0;
            end
        end else begin
            bdir_q <= bdir_d;
            for (int n = 0; n < NCHAN; n++) begin
                bduty_q[n] <= bduty_d[n];
            end
        end
    end
`endif

    assign o_led  = led_q;
    assign o_done = done_q;

endmodule
